// File: rtl/ecg_window_streamer.sv
// ecg_window_streamer
//   Collects free-running ECG samples into a ping-pong buffer of two
//   WINDOW-sample banks and streams each complete window to the FINN
//   classifier over an AXI-Stream master. Reports frame, drop and
//   overflow status.
//
// Ports
//   ap_clk, ap_rst_n          clock; asynchronous active-low reset
//   s_sample_valid/_data      one-cycle sample strobe and value (no backpressure)
//   m_axis_tdata/tvalid/
//   tready/tlast              AXI-Stream master toward the classifier
//   frame_done                one-cycle pulse on the last-beat handshake
//   frames_sent               windows fully transferred (wraps)
//   overflow                  sticky: at least one sample was dropped
//   drop_count                dropped samples (saturates)
//   overflow_clr              synchronous clear of overflow and drop_count
module ecg_window_streamer #(
  parameter int WINDOW = 144,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              s_sample_valid,
  input  logic [DATA_W-1:0] s_sample_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frames_sent,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count,
  input  logic              overflow_clr
);

  localparam int IW = $clog2(WINDOW);
  localparam int AW = $clog2(2 * WINDOW);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Bank b occupies addresses [b*WINDOW, b*WINDOW+WINDOW-1].
  function automatic logic [AW-1:0] bank_addr(input logic bank, input logic [IW-1:0] idx);
    bank_addr = (bank ? AW'(WINDOW) : {AW{1'b0}}) + AW'(idx);
  endfunction

  logic [DATA_W-1:0] r_mem [0:2*WINDOW-1];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic [IW-1:0]     r_wr_idx;
  logic              r_rd_bank;
  logic [IW-1:0]     r_beat;
  state_t            r_state;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic              r_frame_done;
  logic [CNT_W-1:0]  r_frames_sent;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_count;

  logic              w_wr_en;
  logic              w_drop;
  logic              w_wr_last;
  logic              w_hs;
  logic              w_last_hs;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;

  // The full flag of the target bank is the only admission criterion.
  assign w_wr_en   = s_sample_valid && !r_full[r_wr_bank];
  assign w_drop    = s_sample_valid &&  r_full[r_wr_bank];
  assign w_wr_last = (r_wr_idx == IW'(WINDOW - 1));
  assign w_hs      = r_tvalid && m_axis_tready;
  assign w_last_hs = w_hs && r_tlast;
  assign w_wr_addr = bank_addr(r_wr_bank, r_wr_idx);

  // Read address: beat 0 when starting a window, otherwise the beat after the one handing off.
  always_comb begin
    w_rd_addr = {AW{1'b0}};
    if (r_state == ST_IDLE) begin
      w_rd_addr = bank_addr(r_rd_bank, {IW{1'b0}});
    end else begin
      w_rd_addr = bank_addr(r_rd_bank, r_beat + IW'(1));
    end
  end

  // Sample storage; left unreset so it maps onto block or distributed RAM.
  always_ff @(posedge ap_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= s_sample_data;
    end
  end

  // Write pointer: advance per accepted sample, switch banks at window end.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_idx  <= {IW{1'b0}};
      r_wr_bank <= 1'b0;
    end else if (w_wr_en) begin
      if (w_wr_last) begin
        r_wr_idx  <= {IW{1'b0}};
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_idx  <= r_wr_idx + IW'(1);
      end
    end
  end

  // Bank-full flags. A bank being filled is never full and a bank being
  // freed is always full, so the two updates never hit the same bank.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_full <= 2'b00;
    end else begin
      if (w_wr_en && w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_last_hs) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Read FSM. r_tdata doubles as the RAM read register, so the next beat is
  // fetched on the same edge the current one hands off.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= ST_IDLE;
      r_rd_bank     <= 1'b0;
      r_beat        <= {IW{1'b0}};
      r_tdata       <= {DATA_W{1'b0}};
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frames_sent <= {CNT_W{1'b0}};
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
          if (r_full[r_rd_bank]) begin
            r_tdata <= r_mem[w_rd_addr];
            r_beat  <= {IW{1'b0}};
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_tvalid <= 1'b1;
          r_tlast  <= 1'b0;
          r_state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_hs) begin
            if (r_tlast) begin
              r_tvalid      <= 1'b0;
              r_tlast       <= 1'b0;
              r_rd_bank     <= ~r_rd_bank;
              r_frame_done  <= 1'b1;
              r_frames_sent <= r_frames_sent + CNT_W'(1);
              r_state       <= ST_IDLE;
            end else begin
              r_tdata <= r_mem[w_rd_addr];
              r_beat  <= r_beat + IW'(1);
              r_tlast <= ((r_beat + IW'(1)) == IW'(WINDOW - 1));
            end
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Drop accounting; a drop wins over a coincident clear and counts as the first drop.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= {CNT_W{1'b0}};
    end else if (overflow_clr) begin
      r_overflow   <= w_drop;
      r_drop_count <= w_drop ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != {CNT_W{1'b1}}) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign frame_done    = r_frame_done;
  assign frames_sent   = r_frames_sent;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_ecg_window_streamer.sv
// Directed testbench for ecg_window_streamer: nominal frame and latency,
// backpressure, overflow and clear, coincident clear, sustained streaming,
// and reset in the middle of a frame.
module tb_ecg_window_streamer;

  localparam int WINDOW = 144;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              s_sample_valid;
  logic [DATA_W-1:0] s_sample_data;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              frame_done;
  logic [CNT_W-1:0]  frames_sent;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              overflow_clr;

  ecg_window_streamer #(.WINDOW(WINDOW), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_sample_valid(s_sample_valid),
    .s_sample_data (s_sample_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done),
    .frames_sent   (frames_sent),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .overflow_clr  (overflow_clr)
  );

  always #5 ap_clk = ~ap_clk;

  int n_vec = 0;
  int n_err = 0;

  // 0: ready low, 1: ready high, 2: pseudo-random 50%
  int rdy_mode = 0;

  logic [DATA_W-1:0] rx_data [$];
  logic              rx_last [$];
  int fd_cnt    = 0;
  int hold_viol = 0;
  int stalls    = 0;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Ready driver
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1;
      case (rdy_mode)
        1:       m_axis_tready = 1'b1;
        2:       m_axis_tready = 1'(($urandom_range(0, 1)));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Beat monitor: a beat seen valid&&ready at the falling edge transfers on the next rising edge.
  initial begin
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        if (prev_stall) begin
          if (m_axis_tdata !== prev_data || m_axis_tvalid !== 1'b1 || m_axis_tlast !== prev_last)
            hold_viol++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          rx_data.push_back(m_axis_tdata);
          rx_last.push_back(m_axis_tlast);
        end
        if (frame_done) fd_cnt++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        if (prev_stall) stalls++;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic feed_window(input int base, input int gap);
    for (int i = 0; i < WINDOW; i++) begin
      s_sample_valid = 1'b1;
      s_sample_data  = 8'(base + i);
      tick();
      s_sample_valid = 1'b0;
      repeat (gap) tick();
    end
    s_sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (frames_sent != CNT_W'(target) && n < budget) begin
      tick();
      n++;
    end
    chk_vec(tag, frames_sent, target);
  endtask

  task automatic check_frame(input string tag, input int off, input int base);
    if (rx_data.size() >= off + WINDOW) begin
      for (int i = 0; i < WINDOW; i++) begin
        chk_vec({tag, "_data"}, rx_data[off + i], (base + i) & 255);
        chk_vec({tag, "_last"}, rx_last[off + i], (i == WINDOW - 1) ? 1 : 0);
      end
    end else begin
      chk_vec({tag, "_len"}, rx_data.size(), off + WINDOW);
    end
  endtask

  initial begin
    int n;
    int fd0;
    ap_rst_n       = 1'b0;
    s_sample_valid = 1'b0;
    s_sample_data  = '0;
    overflow_clr   = 1'b0;
    repeat (3) tick();

    // Reset state
    chk_vec("rst_tvalid", m_axis_tvalid, 0);
    chk_vec("rst_tlast", m_axis_tlast, 0);
    chk_vec("rst_tdata", m_axis_tdata, 0);
    chk_vec("rst_frame_done", frame_done, 0);
    chk_vec("rst_frames_sent", frames_sent, 0);
    chk_vec("rst_overflow", overflow, 0);
    chk_vec("rst_drop_count", drop_count, 0);
    ap_rst_n = 1'b1;
    rdy_mode = 1;
    repeat (2) tick();

    // Nominal frame with latency check
    rx_data.delete(); rx_last.delete();
    feed_window(0, 0);
    chk_vec("nom_valid_k", m_axis_tvalid, 0);
    tick();
    chk_vec("nom_valid_k1", m_axis_tvalid, 0);
    tick();
    chk_vec("nom_valid_k2", m_axis_tvalid, 1);
    chk_vec("nom_first_data", m_axis_tdata, 0);
    n = 0;
    while (frames_sent != 16'd1 && n < 400) begin
      tick();
      n++;
    end
    chk_vec("nom_frames_sent", frames_sent, 1);
    chk_vec("nom_cycles", n, WINDOW);
    chk_vec("nom_frame_done", frame_done, 1);
    chk_vec("nom_valid_after", m_axis_tvalid, 0);
    tick();
    chk_vec("nom_frame_done_pulse", frame_done, 0);
    chk_vec("nom_overflow", overflow, 0);
    chk_vec("nom_fd_cnt", fd_cnt, 1);
    check_frame("nom", 0, 0);

    // Backpressure
    rx_data.delete(); rx_last.delete();
    stalls = 0;
    rdy_mode = 2;
    feed_window(7, 0);
    wait_frames("bp_frames_sent", 2, 2000);
    check_frame("bp", 0, 7);
    chk_vec("bp_beat_count", rx_data.size(), WINDOW);
    chk_vec("bp_stalls_seen", (stalls > 0) ? 1 : 0, 1);
    chk_vec("bp_hold_viol", hold_viol, 0);

    // Overflow: three windows while stalled
    rdy_mode = 0;
    repeat (4) tick();
    rx_data.delete(); rx_last.delete();
    feed_window(0, 0);
    feed_window(100, 0);
    feed_window(200, 0);
    chk_vec("ovf_drop_count", drop_count, WINDOW);
    chk_vec("ovf_overflow", overflow, 1);
    chk_vec("ovf_frames_sent", frames_sent, 2);
    rdy_mode = 1;
    wait_frames("ovf_drain_frames", 4, 1000);
    repeat (4) tick();
    chk_vec("ovf_beat_count", rx_data.size(), 2 * WINDOW);
    check_frame("ovf_f1", 0, 0);
    check_frame("ovf_f2", WINDOW, 100);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk_vec("clr_overflow", overflow, 0);
    chk_vec("clr_drop_count", drop_count, 0);

    // Coincident clear and drop
    rdy_mode = 0;
    repeat (4) tick();
    rx_data.delete(); rx_last.delete();
    feed_window(30, 0);
    feed_window(60, 0);
    for (int i = 0; i < 5; i++) begin
      s_sample_valid = 1'b1;
      s_sample_data  = 8'hAA;
      tick();
    end
    s_sample_valid = 1'b0;
    chk_vec("pre_coin_drop_count", drop_count, 5);
    s_sample_valid = 1'b1;
    overflow_clr   = 1'b1;
    tick();
    s_sample_valid = 1'b0;
    overflow_clr   = 1'b0;
    chk_vec("coin_overflow", overflow, 1);
    chk_vec("coin_drop_count", drop_count, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk_vec("coin_clr_overflow", overflow, 0);
    chk_vec("coin_clr_drop_count", drop_count, 0);
    rdy_mode = 1;
    wait_frames("coin_drain_frames", 6, 1000);
    repeat (4) tick();
    check_frame("coin_f1", 0, 30);
    check_frame("coin_f2", WINDOW, 60);

    // Sustained streaming: one sample every two cycles
    rx_data.delete(); rx_last.delete();
    fd0 = fd_cnt;
    for (int w = 0; w < 10; w++) feed_window(w * 13, 1);
    wait_frames("sus_frames_sent", 16, 2000);
    repeat (4) tick();
    chk_vec("sus_drop_count", drop_count, 0);
    chk_vec("sus_overflow", overflow, 0);
    chk_vec("sus_beat_count", rx_data.size(), 10 * WINDOW);
    chk_vec("sus_fd_cnt", fd_cnt - fd0, 10);
    for (int w = 0; w < 10; w++) check_frame("sus", w * WINDOW, w * 13);

    // Reset in the middle of a frame
    rx_data.delete(); rx_last.delete();
    feed_window(200, 0);
    n = 0;
    while (rx_data.size() < 70 && n < 1000) begin
      tick();
      n++;
    end
    chk_vec("mid_beats_before_rst", rx_data.size(), 70);
    ap_rst_n = 1'b0;
    #1;
    chk_vec("mid_rst_tvalid", m_axis_tvalid, 0);
    chk_vec("mid_rst_frames_sent", frames_sent, 0);
    chk_vec("mid_rst_drop_count", drop_count, 0);
    chk_vec("mid_rst_frame_done", frame_done, 0);
    repeat (3) tick();
    chk_vec("mid_rst_hold_tvalid", m_axis_tvalid, 0);
    ap_rst_n = 1'b1;
    repeat (2) tick();
    rx_data.delete(); rx_last.delete();
    feed_window(90, 0);
    wait_frames("mid_fresh_frames", 1, 1000);
    repeat (4) tick();
    chk_vec("mid_fresh_beats", rx_data.size(), WINDOW);
    check_frame("mid_fresh", 0, 90);
    chk_vec("final_hold_viol", hold_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
